// File: rtl/pwm_generator.sv
// rtl/pwm_generator.sv - 16-pin output driver with shared double-buffered 8-bit PWM
//
// Ports:
//   clk, rst                           clock and asynchronous active-high reset
//   en_reg_out_7_0 / en_reg_out_15_8   per-pin output enable (pin forced low when 0)
//   en_reg_pwm_7_0 / en_reg_pwm_15_8   per-pin mode (0 = forced high, 1 = PWM waveform)
//   pwm_duty_cycle                     requested duty in 1/256 units, 8'hFF means 100%
//   out                                registered pin drive, out[i] is pin i
//   pwm_period_start                   one-clk pulse on the edge that starts a period
//   pwm_level                          registered raw PWM waveform

module pwm_generator #(
    parameter int DIV       = 13,
    parameter int DIV_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        pwm_period_start,
    output logic        pwm_level
);

    // The prescaler wraps at DIV-1 rather than at its natural width.
    localparam logic [DIV_WIDTH-1:0] PRESC_LAST = DIV_WIDTH'(DIV - 1);

    logic [DIV_WIDTH-1:0] presc;
    logic [7:0]           cnt;
    logic [7:0]           duty_active;

    logic        tick;
    logic        boundary;
    logic        raw;
    logic [15:0] en_out;
    logic [15:0] en_pwm;
    logic [15:0] next_out;

    assign tick     = (presc == PRESC_LAST);
    assign boundary = tick && (cnt == 8'hFF);

    // Full scale is treated as constant high so 8'hFF never leaves a one-tick low gap.
    assign raw = (duty_active == 8'hFF) ? 1'b1 : (cnt < duty_active);

    assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // Enable wins over mode; a non-PWM enabled pin is driven high.
    assign next_out = en_out & (~en_pwm | {16{raw}});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc            <= '0;
            cnt              <= 8'h00;
            duty_active      <= 8'h00;
            out              <= 16'h0000;
            pwm_period_start <= 1'b0;
            pwm_level        <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + DIV_WIDTH'(1);
            if (tick) begin
                cnt <= cnt + 8'd1;
            end
            // Duty is only sampled at the wrap so a period never sees a mid-period change.
            if (boundary) begin
                duty_active <= pwm_duty_cycle;
            end
            pwm_period_start <= boundary;
            pwm_level        <= raw;
            out              <= next_out;
        end
    end

endmodule

// File: tb/tb_pwm_generator.sv
// tb/tb_pwm_generator.sv - directed self-checking bench for pwm_generator (DIV=4)

module tb_pwm_generator;

    logic        clk;
    logic        rst;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        pwm_period_start;
    logic        pwm_level;

    int n_checks = 0;
    int n_fail   = 0;

    pwm_generator #(
        .DIV       (4),
        .DIV_WIDTH (12)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .en_reg_out_7_0   (en_reg_out_7_0),
        .en_reg_out_15_8  (en_reg_out_15_8),
        .en_reg_pwm_7_0   (en_reg_pwm_7_0),
        .en_reg_pwm_15_8  (en_reg_pwm_15_8),
        .pwm_duty_cycle   (pwm_duty_cycle),
        .out              (out),
        .pwm_period_start (pwm_period_start),
        .pwm_level        (pwm_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits (on negedges) for the next period pulse, bounded.
    task automatic wait_period_start(input string name, input int limit);
        int found;
        found = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (pwm_period_start === 1'b1) begin
                found = 1;
                break;
            end
        end
        n_checks++;
        if (found !== 1) begin
            n_fail++;
            $display("FAIL %s: pwm_period_start not seen within %0d clks (got 0, need 1)", name, limit);
        end
    endtask

    task automatic test_reset;
        rst             = 1'b1;
        en_reg_out_7_0  = 8'h00;
        en_reg_out_15_8 = 8'h00;
        en_reg_pwm_7_0  = 8'h00;
        en_reg_pwm_15_8 = 8'h00;
        pwm_duty_cycle  = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({out, pwm_period_start, pwm_level} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_state: out=%h start=%b level=%b, need 0000/0/0", out, pwm_period_start, pwm_level);
        end
        rst = 1'b0;
    endtask

    task automatic test_static_enable;
        int bad;
        @(negedge clk);
        en_reg_out_7_0 = 8'h01;
        #1;
        n_checks++;
        if (out !== 16'h0000) begin
            n_fail++;
            $display("FAIL static_before_edge: out=%h, need 0000", out);
        end
        @(negedge clk);
        n_checks++;
        if (out !== 16'h0001) begin
            n_fail++;
            $display("FAIL static_one_clk: out=%h, need 0001", out);
        end
        bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out !== 16'h0001) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL static_stable: %0d clks differed from 0001, need 0", bad);
        end
    endtask

    task automatic test_half_duty;
        int bad_wave;
        int bad_lvl;
        int bad_start;
        en_reg_out_7_0  = 8'hFF;
        en_reg_out_15_8 = 8'hFF;
        en_reg_pwm_7_0  = 8'hFF;
        en_reg_pwm_15_8 = 8'hFF;
        pwm_duty_cycle  = 8'h80;
        wait_period_start("half_first_start", 2100);
        bad_wave = 0; bad_lvl = 0; bad_start = 0;
        for (int k = 1; k <= 1024; k++) begin
            @(negedge clk);
            if (out !== ((k <= 512) ? 16'hFFFF : 16'h0000)) bad_wave++;
            if (pwm_level !== (k <= 512)) bad_lvl++;
            if (pwm_period_start !== (k == 1024)) bad_start++;
        end
        n_checks++;
        if (bad_wave !== 0) begin
            n_fail++;
            $display("FAIL half_wave: %0d clks off the 512 high / 512 low shape, need 0", bad_wave);
        end
        n_checks++;
        if (bad_lvl !== 0) begin
            n_fail++;
            $display("FAIL half_level: %0d clks of pwm_level wrong, need 0", bad_lvl);
        end
        n_checks++;
        if (bad_start !== 0) begin
            n_fail++;
            $display("FAIL half_period_pulse: %0d clks with wrong pulse, need 0 (pulse only at 1024)", bad_start);
        end
    endtask

    task automatic test_duty_extremes;
        int bad_zero;
        int bad_full;
        // Current period still runs 8'h80; 8'h00 takes over at the next boundary.
        pwm_duty_cycle = 8'h00;
        wait_period_start("extreme_zero_start", 1100);
        bad_zero = 0;
        for (int k = 1; k <= 1024; k++) begin
            @(negedge clk);
            if (k == 500) pwm_duty_cycle = 8'hFF;
            if (out !== 16'h0000) bad_zero++;
        end
        n_checks++;
        if (bad_zero !== 0) begin
            n_fail++;
            $display("FAIL duty_zero: %0d clks not 0000, need 0", bad_zero);
        end
        n_checks++;
        if (pwm_period_start !== 1'b1) begin
            n_fail++;
            $display("FAIL duty_zero_boundary: start=%b, need 1", pwm_period_start);
        end
        bad_full = 0;
        for (int k = 1; k <= 1025; k++) begin
            @(negedge clk);
            if (out !== 16'hFFFF) bad_full++;
        end
        n_checks++;
        if (bad_full !== 0) begin
            n_fail++;
            $display("FAIL duty_full: %0d clks not FFFF (incl. across boundary), need 0", bad_full);
        end
    endtask

    task automatic test_midperiod_update;
        int highs1;
        int highs2;
        int bad_shape;
        pwm_duty_cycle = 8'h40;
        wait_period_start("mid_load_40", 1100);
        highs1 = 0; highs2 = 0; bad_shape = 0;
        for (int k = 1; k <= 1024; k++) begin
            @(negedge clk);
            if (k == 64) pwm_duty_cycle = 8'hC0;  // counter sits at 8'h10 here
            if (out === 16'hFFFF) highs1++;
            if (out !== ((k <= 256) ? 16'hFFFF : 16'h0000)) bad_shape++;
        end
        for (int k = 1; k <= 1024; k++) begin
            @(negedge clk);
            if (out === 16'hFFFF) highs2++;
            if (out !== ((k <= 768) ? 16'hFFFF : 16'h0000)) bad_shape++;
        end
        n_checks++;
        if (highs1 !== 256) begin
            n_fail++;
            $display("FAIL mid_current_period: high clks=%0d, need 256", highs1);
        end
        n_checks++;
        if (highs2 !== 768) begin
            n_fail++;
            $display("FAIL mid_next_period: high clks=%0d, need 768", highs2);
        end
        n_checks++;
        if (bad_shape !== 0) begin
            n_fail++;
            $display("FAIL mid_shape: %0d clks out of place, need 0", bad_shape);
        end
    endtask

    task automatic test_pin_modes;
        int bad;
        en_reg_out_7_0  = 8'hDF;
        en_reg_out_15_8 = 8'hFF;
        en_reg_pwm_7_0  = 8'hFF;
        en_reg_pwm_15_8 = 8'h00;
        pwm_duty_cycle  = 8'h40;
        @(negedge clk);
        n_checks++;
        if (out[15:8] !== 8'hFF || out[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL modes_one_clk: out=%h, need [15:8]=FF and bit5=0", out);
        end
        wait_period_start("modes_start", 1100);
        bad = 0;
        for (int k = 1; k <= 1024; k++) begin
            @(negedge clk);
            if (out !== ((k <= 256) ? 16'hFFDF : 16'hFF00)) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL modes_wave: %0d clks wrong (high FFDF x256, low FF00), need 0", bad);
        end
    endtask

    task automatic test_async_reset;
        int bad_out;
        int bad_start;
        en_reg_out_7_0  = 8'hFF;
        en_reg_out_15_8 = 8'hFF;
        en_reg_pwm_7_0  = 8'hFF;
        en_reg_pwm_15_8 = 8'hFF;
        pwm_duty_cycle  = 8'hFF;
        wait_period_start("areset_start", 1100);
        repeat (300) @(negedge clk);
        n_checks++;
        if (out !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL areset_pre: out=%h, need FFFF", out);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out, pwm_level} !== 17'h0) begin
            n_fail++;
            $display("FAIL areset_immediate: out=%h level=%b, need 0000/0 before clk edge", out, pwm_level);
        end
        @(negedge clk);
        rst = 1'b0;
        bad_out = 0; bad_start = 0;
        for (int k = 1; k <= 1024; k++) begin
            @(negedge clk);
            if (out !== 16'h0000) bad_out++;
            if (pwm_period_start !== (k == 1024)) bad_start++;
        end
        n_checks++;
        if (bad_out !== 0) begin
            n_fail++;
            $display("FAIL areset_first_period_low: %0d clks not 0000, need 0", bad_out);
        end
        n_checks++;
        if (bad_start !== 0) begin
            n_fail++;
            $display("FAIL areset_restart: %0d clks with wrong pulse, need 0 (pulse at 1024)", bad_start);
        end
        @(negedge clk);
        n_checks++;
        if (out !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL areset_second_period: out=%h, need FFFF", out);
        end
    endtask

    initial begin
        test_reset();
        test_static_enable();
        test_half_duty();
        test_duty_extremes();
        test_midperiod_update();
        test_pin_modes();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
